mux_lut_pipelined: RTL

//   Multi-lane, runtime-programmable K-input logic function (LUT) built as a

---
 rtl/mux_lut_pipelined.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mux_lut_pipelined.sv
// mux_lut_pipelined
//   Runtime-programmable K-input logic function applied to W lanes in
//   parallel. The lookup is a registered 2:1 mux tree: level l consumes
//   select bit l and halves the candidate set, so the latency is K cycles.
//   The truth table is shifted serially into a shadow register. It is
//   copied to the active table only when the pipeline is empty, so every
//   result is computed with a single table.
//
// Ports
//   clk        clock, all state on posedge
//   rst        asynchronous active-high reset
//   cfg_valid  cfg_bit offered
//   cfg_ready  shadow accepts cfg_bit (low while draining)
//   cfg_bit    next table bit; the first accepted bit is entry 0
//   configured active table valid
//   in_valid   lane inputs offered
//   in_ready   pipeline accepts lane inputs
//   in_x       lane i selects = in_x[i*K +: K], bit 0 used by level 0
//   out_valid  one-cycle pulse per result
//   out_y      out_y[i] = active_table[lane i selects], held between results

module mux_lut_pipelined #(
  parameter int K = 2,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic           cfg_bit,
  output logic           configured,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*K-1:0] in_x,
  output logic           out_valid,
  output logic [W-1:0]   out_y
);

  localparam int N  = 1 << K;
  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] UNCFG = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  shadow;
  logic [N-1:0]  shadow_next;
  logic [N-1:0]  active;
  logic [CW-1:0] cfg_cnt;
  logic          cfg_xfer;
  logic          in_xfer;
  logic          last_bit;
  logic [K-1:0]  stage_vld;

  assign in_ready    = (state == RUN);
  assign cfg_ready   = (state != DRAIN);
  assign configured  = (state == RUN) || (state == DRAIN);
  assign cfg_xfer    = cfg_valid && cfg_ready;
  assign in_xfer     = in_valid && in_ready;
  assign shadow_next = {cfg_bit, shadow[N-1:1]};
  assign last_bit    = cfg_xfer && (cfg_cnt == CW'(N - 1));

  // Shadow loading and table-commit control. The very first table is
  // committed straight from the completing shift because nothing can be
  // in flight yet; later tables wait in DRAIN until every level is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= UNCFG;
      shadow  <= '0;
      active  <= '0;
      cfg_cnt <= '0;
    end else begin
      if (cfg_xfer) begin
        shadow  <= shadow_next;
        cfg_cnt <= last_bit ? '0 : cfg_cnt + 1'b1;
      end
      case (state)
        UNCFG: begin
          if (last_bit) begin
            active <= shadow_next;
            state  <= RUN;
          end
        end
        RUN: begin
          if (last_bit) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (stage_vld == '0) begin
            active <= shadow;
            state  <= RUN;
          end
        end
        default: state <= UNCFG;
      endcase
    end
  end

  for (genvar l = 0; l < K; l++) begin : g_lvl
    localparam int CIN  = N >> l;
    localparam int COUT = N >> (l + 1);

    logic [W-1:0][CIN-1:0]  cand_in;
    logic [W-1:0][COUT-1:0] cand_nxt;
    logic [W-1:0][COUT-1:0] cand;
    logic [W-1:0]           sel;
    logic                   vld_in;
    logic                   vld;

    if (l == 0) begin : g_head
      for (genvar i = 0; i < W; i++) begin : g_lane
        assign cand_in[i] = active;
        assign sel[i]     = in_x[i*K];
      end
      assign vld_in = in_xfer;
    end else begin : g_body
      // Select bit l is needed l cycles after acceptance, so it rides a
      // short delay line instead of travelling with the candidates.
      logic [W-1:0] sel_dly [l];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int m = 0; m < l; m++) begin
            sel_dly[m] <= '0;
          end
        end else begin
          for (int i = 0; i < W; i++) begin
            sel_dly[0][i] <= in_x[i*K + l];
          end
          for (int m = 1; m < l; m++) begin
            sel_dly[m] <= sel_dly[m-1];
          end
        end
      end

      assign cand_in = g_lvl[l-1].cand;
      assign vld_in  = g_lvl[l-1].vld;
      assign sel     = sel_dly[l-1];
    end

    always_comb begin
      cand_nxt = '0;
      for (int i = 0; i < W; i++) begin
        for (int j = 0; j < COUT; j++) begin
          cand_nxt[i][j] = sel[i] ? cand_in[i][2*j+1] : cand_in[i][2*j];
        end
      end
    end

    // Candidates load only with a valid item so the last level doubles
    // as the output register and holds its value between results.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cand <= '0;
        vld  <= 1'b0;
      end else begin
        vld <= vld_in;
        if (vld_in) begin
          cand <= cand_nxt;
        end
      end
    end

    assign stage_vld[l] = vld;
  end

  assign out_valid = g_lvl[K-1].vld;

  for (genvar i = 0; i < W; i++) begin : g_out
    assign out_y[i] = g_lvl[K-1].cand[i][0];
  end

endmodule
